// File: rtl/crc_pkg.sv
// Shared CRC helpers and the appender state enum.
package crc_pkg;

  typedef enum logic {PASS, APPEND} crc_state_e;

  // Reverses the low `width` bits of v; bits above width come back zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[i] = v[width-1-i];
    return r;
  endfunction

  // Bitwise MSB-first CRC update over one byte; crc/poly live in the low `width` bits.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] data,
                                                input logic [31:0] poly, input int width,
                                                input bit reflect);
    logic [31:0] rev;
    logic [7:0]  d;
    logic [31:0] c;
    logic [31:0] mask;
    logic        fb;
    rev  = bit_reverse({24'd0, data}, 8);
    d    = reflect ? rev[7:0] : data;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    c    = crc & mask;
    for (int i = 7; i >= 0; i--) begin
      fb = c[width-1] ^ d[i];
      c  = (c << 1) & mask;
      if (fb) c = c ^ (poly & mask);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_frame_append.sv
// Byte-stream CRC appender: forwards payload through a single output slot and
// appends the finished CRC after s_last, flagging the final CRC byte with m_last.
module crc_frame_append
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = 'h07,
  parameter logic [CRC_WIDTH-1:0] INIT      = '0,
  parameter bit                   REFLECT   = 1'b0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [CRC_WIDTH-1:0] crc_o,
  output logic                 crc_valid_o
);

  localparam int CRC_BYTES = CRC_WIDTH / 8;
  localparam int IDX_W     = 2;

  crc_state_e           state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [CRC_WIDTH-1:0] crc_out_q, crc_out_d;
  logic                 crc_valid_q, crc_valid_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic        slot_free, accept, last_crc_byte;
  logic [31:0] step32, fin32, crc_sh;
  logic [IDX_W-1:0] sel;

  assign slot_free     = !m_valid_q || m_ready;
  assign s_ready       = (state_q == PASS) && slot_free;
  assign accept        = s_valid && s_ready;
  assign last_crc_byte = (idx_q == IDX_W'(CRC_BYTES - 1));

  assign step32 = crc_byte_step(32'(crc_q), s_data, 32'(POLY), CRC_WIDTH, REFLECT);
  assign fin32  = (REFLECT ? bit_reverse(step32, CRC_WIDTH) : step32) ^ 32'(XOR_OUT);

  // Trailer goes MSB-first for normal CRCs, LSB-first for reflected ones.
  assign sel    = REFLECT ? idx_q : (IDX_W'(CRC_BYTES - 1) - idx_q);
  assign crc_sh = 32'(crc_out_q) >> {sel, 3'b000};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= PASS;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (accept && s_last) state_d = APPEND;
      APPEND:  if (slot_free && last_crc_byte) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    idx_d       = idx_q;
    case (state_q)
      PASS: begin
        if (accept) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = step32[CRC_WIDTH-1:0];
          if (s_last) begin
            crc_out_d   = fin32[CRC_WIDTH-1:0];
            crc_valid_d = 1'b1;
            idx_d       = '0;
          end
        end else if (slot_free) begin
          m_valid_d = 1'b0;
        end
      end
      APPEND: begin
        if (slot_free) begin
          m_data_d  = crc_sh[7:0];
          m_valid_d = 1'b1;
          m_last_d  = last_crc_byte;
          idx_d     = idx_q + 1'b1;
          if (last_crc_byte) crc_d = INIT;
        end
      end
      default: ;
    endcase
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign crc_o       = crc_out_q;
  assign crc_valid_o = crc_valid_q;

endmodule

// File: tb/tb_crc_frame_append.sv
// Directed bench for crc_frame_append: CRC-8, CRC-16/CCITT-FALSE and CRC-32 instances.
module tb_crc_frame_append;

  typedef logic [7:0] bq_t[$];
  typedef logic       lq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic       m_ready = 1'b1;
  logic       wide_en = 1'b0;
  logic       rnd_en  = 1'b0;
  logic       s_valid_w;
  assign s_valid_w = s_valid & wide_en;

  logic        s_ready8, m_valid8, m_last8, crcv8;
  logic [7:0]  m_data8, crc8;
  logic        s_ready16, m_valid16, m_last16, crcv16;
  logic [7:0]  m_data16;
  logic [15:0] crc16;
  logic        s_ready32, m_valid32, m_last32, crcv32;
  logic [7:0]  m_data32;
  logic [31:0] crc32;

  crc_frame_append #(.CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00), .REFLECT(1'b0), .XOR_OUT(8'h00)) dut8 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready8), .m_data(m_data8), .m_valid(m_valid8), .m_last(m_last8),
    .m_ready(m_ready), .crc_o(crc8), .crc_valid_o(crcv8));

  crc_frame_append #(.CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFLECT(1'b0), .XOR_OUT(16'h0000)) dut16 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid_w), .s_last(s_last),
    .s_ready(s_ready16), .m_data(m_data16), .m_valid(m_valid16), .m_last(m_last16),
    .m_ready(m_ready), .crc_o(crc16), .crc_valid_o(crcv16));

  crc_frame_append #(.CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFLECT(1'b1),
                     .XOR_OUT(32'hFFFFFFFF)) dut32 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid_w), .s_last(s_last),
    .s_ready(s_ready32), .m_data(m_data32), .m_valid(m_valid32), .m_last(m_last32),
    .m_ready(m_ready), .crc_o(crc32), .crc_valid_o(crcv32));

  int checks = 0;
  int errors = 0;
  int stall_viol = 0;

  bq_t cap8_d, cap16_d, cap32_d;
  lq_t cap8_l, cap16_l, cap32_l;
  logic [7:0]  crc8_q[$];
  logic [15:0] crc16_q[$];
  logic [31:0] crc32_q[$];

  initial forever begin
    @(posedge clk);
    #1 m_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output capture and stall-stability watch, sampled mid-cycle.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_d;
    logic       stall_l;
    stall_prev = 1'b0; stall_d = '0; stall_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (m_valid8  && m_ready) begin cap8_d.push_back(m_data8);   cap8_l.push_back(m_last8);   end
        if (m_valid16 && m_ready) begin cap16_d.push_back(m_data16); cap16_l.push_back(m_last16); end
        if (m_valid32 && m_ready) begin cap32_d.push_back(m_data32); cap32_l.push_back(m_last32); end
        if (crcv8)  crc8_q.push_back(crc8);
        if (crcv16) crc16_q.push_back(crc16);
        if (crcv32) crc32_q.push_back(crc32);
        if (stall_prev && (m_valid8 !== 1'b1 || m_data8 !== stall_d || m_last8 !== stall_l)) stall_viol++;
        if (m_valid8 && !m_ready && s_ready8) stall_viol++;
        stall_prev = m_valid8 && !m_ready;
        stall_d    = m_data8;
        stall_l    = m_last8;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic clear_caps();
    cap8_d.delete();  cap8_l.delete();  cap16_d.delete(); cap16_l.delete();
    cap32_d.delete(); cap32_l.delete(); crc8_q.delete();  crc16_q.delete(); crc32_q.delete();
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready8 && n < 200) begin @(negedge clk); n++; end
    if (!s_ready8) begin
      checks++; errors++;
      $display("FAIL accept_timeout s_ready stayed low for %0d cycles", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bq_t f);
    for (int i = 0; i < f.size(); i++) begin
      s_data  = f[i];
      s_valid = 1'b1;
      s_last  = (i == f.size() - 1);
      wait_accept();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_cap8(input int n);
    int c;
    c = 0;
    while (cap8_d.size() < n && c < 2000) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid8 !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid8); end
    checks++; if (m_last8 !== 1'b0)   begin errors++; $display("FAIL reset_m_last got %b want 0", m_last8); end
    checks++; if (crcv8 !== 1'b0)     begin errors++; $display("FAIL reset_crc_valid got %b want 0", crcv8); end
    checks++; if (m_data8 !== 8'h00)  begin errors++; $display("FAIL reset_m_data got %h want 00", m_data8); end
    checks++; if (crc32 !== 32'h0)    begin errors++; $display("FAIL reset_crc_o got %h want 0", crc32); end
    checks++; if (s_ready8 !== 1'b1)  begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready8); end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_single_byte();
    clear_caps();
    s_data = 8'hAB; s_valid = 1'b1; s_last = 1'b1;
    @(negedge clk);
    checks++; if (s_ready8 !== 1'b1) begin errors++; $display("FAIL single_s_ready got %b want 1", s_ready8); end
    @(posedge clk); #1 s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++; if ({m_valid8, m_last8, m_data8} !== {2'b10, 8'hAB})
      begin errors++; $display("FAIL single_payload got v%b l%b %h want v1 l0 ab", m_valid8, m_last8, m_data8); end
    checks++; if ({crcv8, crc8} !== {1'b1, 8'h58})
      begin errors++; $display("FAIL single_crc_pulse got %b %h want 1 58", crcv8, crc8); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({m_valid8, m_last8, m_data8} !== {2'b11, 8'h58})
      begin errors++; $display("FAIL single_trailer got v%b l%b %h want v1 l1 58", m_valid8, m_last8, m_data8); end
    checks++; if (crcv8 !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", crcv8); end
    checks++; if (s_ready8 !== 1'b1) begin errors++; $display("FAIL single_no_bubble got %b want 1", s_ready8); end
    @(posedge clk); #1;
  endtask

  task automatic test_check_string();
    bq_t s, e8, t16, t32;
    s   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    e8  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    t16 = '{8'h29, 8'hB1};
    t32 = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    repeat (4) @(posedge clk); #1;
    clear_caps();
    wide_en = 1'b1;
    send_frame(s);
    wide_en = 1'b0;
    repeat (8) @(posedge clk); #1;
    checks++; if (cap8_d.size() != 10 || cap16_d.size() != 11 || cap32_d.size() != 13)
      begin errors++; $display("FAIL str_counts got %0d %0d %0d want 10 11 13", cap8_d.size(), cap16_d.size(), cap32_d.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (cap8_d[i] !== e8[i] || cap8_l[i] !== (i == 9))
          begin errors++; $display("FAIL str8_byte%0d got %h l%b want %h", i, cap8_d[i], cap8_l[i], e8[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (cap16_d[9+i] !== t16[i] || cap16_l[9+i] !== (i == 1))
          begin errors++; $display("FAIL str16_trailer%0d got %h l%b want %h", i, cap16_d[9+i], cap16_l[9+i], t16[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (cap32_d[9+i] !== t32[i] || cap32_l[9+i] !== (i == 3))
          begin errors++; $display("FAIL str32_trailer%0d got %h l%b want %h", i, cap32_d[9+i], cap32_l[9+i], t32[i]); end
      end
    end
    checks++; if (crc8_q.size() != 1 || crc8_q[0] !== 8'hF4)
      begin errors++; $display("FAIL str8_crc_o got n%0d %h want 1 f4", crc8_q.size(), crc8); end
    checks++; if (crc16_q.size() != 1 || crc16_q[0] !== 16'h29B1)
      begin errors++; $display("FAIL str16_crc_o got n%0d %h want 1 29b1", crc16_q.size(), crc16); end
    checks++; if (crc32_q.size() != 1 || crc32_q[0] !== 32'hCBF43926)
      begin errors++; $display("FAIL str32_crc_o got n%0d %h want 1 cbf43926", crc32_q.size(), crc32); end
  endtask

  task automatic test_back_to_back();
    bq_t fa, fs, ed;
    lq_t el;
    fa = '{8'hAB};
    fs = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ed = '{8'hAB, 8'h58, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4, 8'hAB, 8'h58};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_caps();
    stall_viol = 0;
    rnd_en = 1'b1;
    send_frame(fa);
    send_frame(fs);
    send_frame(fa);
    wait_cap8(14);
    rnd_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (cap8_d.size() != 14)
      begin errors++; $display("FAIL b2b_count got %0d want 14", cap8_d.size()); end
    else begin
      for (int i = 0; i < 14; i++) begin
        checks++; if (cap8_d[i] !== ed[i] || cap8_l[i] !== el[i])
          begin errors++; $display("FAIL b2b_byte%0d got %h l%b want %h l%b", i, cap8_d[i], cap8_l[i], ed[i], el[i]); end
      end
    end
    checks++; if (crc8_q.size() != 3 || crc8_q[0] !== 8'h58 || crc8_q[1] !== 8'hF4 || crc8_q[2] !== 8'h58)
      begin errors++; $display("FAIL b2b_crc_pulses got n%0d want 3 (58 f4 58)", crc8_q.size()); end
    checks++; if (stall_viol != 0)
      begin errors++; $display("FAIL b2b_stall_stability got %0d violations want 0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    bq_t fa;
    fa = '{8'hAB};
    for (int i = 0; i < 3; i++) begin
      s_data = 8'h31 + 8'(i); s_valid = 1'b1; s_last = 1'b0;
      wait_accept();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (m_valid8 !== 1'b0 || crcv8 !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs got v%b c%b want v0 c0", m_valid8, crcv8); end
    clear_caps();
    @(posedge clk); #1;
    send_frame(fa);
    repeat (5) @(posedge clk); #1;
    checks++; if (cap8_d.size() != 2 || cap8_d[0] !== 8'hAB || cap8_d[1] !== 8'h58 || cap8_l[1] !== 1'b1)
      begin errors++; $display("FAIL midreset_frame got n%0d want ab 58", cap8_d.size()); end
    checks++; if (crc8_q.size() != 1 || crc8_q[0] !== 8'h58)
      begin errors++; $display("FAIL midreset_crc got n%0d %h want 1 58", crc8_q.size(), crc8); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_check_string();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_frame_append.md
# crc_frame_append

Streaming CRC appender that sits directly upstream of the link/serializer, after the payload source. It accepts an 8-bit valid/ready byte stream framed by `s_last`, forwards each byte unchanged, and computes the frame CRC on the fly. After the last payload byte it appends the CRC bytes and marks the final CRC byte with `m_last`. It also reports the finished CRC on a side port for status and debug.

## Interface
Parameters:
- `CRC_WIDTH`, 8: CRC width in bits; must be 8, 16 or 32. `CRC_BYTES = CRC_WIDTH/8`.
- `POLY`, 'h07: generator polynomial, normal (non-reflected) form, implicit top bit.
- `INIT`, '0: CRC register value at the start of each frame.
- `REFLECT`, 0: 1 = reflect input bytes and the final CRC (LSB-first algorithms).
- `XOR_OUT`, '0: XORed into the final CRC after reflection.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  payload byte valid.
- `s_last`  in  1  last payload byte of the frame.
- `s_ready`  out  1  block accepts the payload byte.
- `m_data`  out  8  output byte: payload or CRC.
- `m_valid`  out  1  output byte valid.
- `m_last`  out  1  final CRC byte of the frame.
- `m_ready`  in  1  downstream accepts the output byte.
- `crc_o`  out  CRC_WIDTH  final CRC of the most recent frame.
- `crc_valid_o`  out  1  one-cycle pulse; `crc_o` has just updated.

## Operation
- A beat transfers when valid and ready are both 1 on a rising edge. This applies to both the input and the output side.
- The output side has a single register slot. The slot is free when `!m_valid || m_ready`.
- FSM states are PASS and APPEND.
- **PASS**
  - `s_ready = slot free`.
  - On an accepted payload beat: `m_data <= s_data`, `m_valid <= 1`, `m_last <= 0`, `crc <= step(crc, s_data)`.
  - If `s_last` is also set: `crc_o <= final(step(crc, s_data))`, pulse `crc_valid_o`, load `idx <= 0`, go to APPEND.
  - If the slot frees with no accepted beat: `m_valid <= 0`.
- **APPEND**
  - `s_ready = 0`.
  - When the slot is free, load CRC byte `idx` from `crc_o` into `m_data` with `m_valid <= 1`, then increment `idx`.
  - Byte order is MSB-first when REFLECT=0 and LSB-first when REFLECT=1.
  - On the byte with `idx == CRC_BYTES-1`: set `m_last <= 1`, set `crc <= INIT`, go to PASS.
- `step` is a bitwise MSB-first CRC update over 8 bits, with the input byte bit-reversed first when REFLECT=1.
- `final(c)` is `(REFLECT ? reverse(c) : c) ^ XOR_OUT`.
- Every frame has at least one payload byte. A zero-length frame cannot be expressed.
- `s_data` and `s_last` are ignored when `s_valid=0`.

## Timing
Reset:
- `m_valid`, `m_last`, `crc_valid_o` = 0.
- `m_data` = 0, `crc_o` = 0, crc register = INIT, state = PASS, `idx` = 0.

Latency:
- A payload byte accepted at edge k is presented on `m_data` from cycle k+1.
- If the last payload byte is accepted at edge k, `crc_valid_o` is high during cycle k+1 only.
- With `m_ready` held at 1, CRC byte i is presented in cycle k+2+i.

Throughput:
- One byte per cycle when `m_ready` is 1.
- No bubble between the final CRC byte and the next frame: the edge that loads the last CRC byte returns the FSM to PASS, so the next payload byte can be accepted on the following edge.

Backpressure:
- While `m_ready=0`, `m_valid`, `m_data` and `m_last` hold stable, and `s_ready=0` because the slot is full.

Reset mid-frame:
- The partial frame is discarded and no CRC bytes are emitted.
- All outputs take their reset values on the next edge.

## Structure
- Package `crc_pkg` holds:
  - the state enum (PASS, APPEND);
  - function `crc_byte_step(crc, byte, poly, width, reflect)`;
  - function `bit_reverse`.
- `crc_byte_step` is shared with the existing CRC cores.
- No sub-module is needed. The CRC step is a package function, and the FSM plus output register live in the single module.

## Test plan
- CRC_WIDTH=8, POLY=07, INIT=00, single byte AB with `s_last` → output AB, then 58 with `m_last`; `crc_o`=58 with one pulse.
- CRC_WIDTH=8, POLY=07, input ASCII "123456789" → 9 bytes passed through, then F4 with `m_last`.
- CRC_WIDTH=16, POLY=1021, INIT=FFFF, input "123456789" → trailer 29 B1 (MSB-first).
- CRC_WIDTH=32, POLY=04C11DB7, INIT=FFFFFFFF, REFLECT=1, XOR_OUT=FFFFFFFF, input "123456789" → trailer 26 39 F4 CB.
- Back-to-back frames with random `m_ready` → outputs stable while stalled; per-frame CRCs match the model; the CRC register reloads INIT between frames.
- `reset_n` low for one cycle mid-payload → `m_valid`=0 next cycle; a new frame AB then yields 58.
